// File: rtl/rasterizer_mem_arbiter_if.sv
// Bus bundle for rasterizer_mem_arbiter: the three requester Avalon-MM
// slave ports (s_*) and the single downstream SDRAM master port (m_*).
// The "slave" modport is the arbiter's view; "master" is the environment's.
interface rasterizer_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 26
);
  logic [3*ADDR_W-1:0] s_address;
  logic [2:0]          s_read;
  logic [2:0]          s_write;
  logic [11:0]         s_byteenable;
  logic [95:0]         s_writedata;
  logic [2:0]          s_waitrequest;
  logic [95:0]         s_readdata;
  logic [2:0]          s_readdatavalid;

  logic [ADDR_W-1:0]   m_address;
  logic                m_read;
  logic                m_write;
  logic [3:0]          m_byteenable;
  logic [31:0]         m_writedata;
  logic [31:0]         m_readdata;
  logic                m_readdatavalid;
  logic                m_waitrequest;

  modport slave (
    input  s_address, s_read, s_write, s_byteenable, s_writedata,
    output s_waitrequest, s_readdata, s_readdatavalid,
    output m_address, m_read, m_write, m_byteenable, m_writedata,
    input  m_readdata, m_readdatavalid, m_waitrequest
  );

  modport master (
    output s_address, s_read, s_write, s_byteenable, s_writedata,
    input  s_waitrequest, s_readdata, s_readdatavalid,
    input  m_address, m_read, m_write, m_byteenable, m_writedata,
    output m_readdata, m_readdatavalid, m_waitrequest
  );
endinterface

// File: rtl/rasterizer_mem_arbiter.sv
// Three-way Avalon-MM arbiter for the rasterizer SDRAM port.
// One transfer at a time (IDLE/GRANT), read requester IDs tracked in a FIFO
// so returned words are steered back to their issuer.
// Optional macro ARB_FIXED_PRIORITY_EN: fixed priority 2 > 1 > 0 instead of
// round-robin.
module rasterizer_mem_arbiter #(
  parameter int unsigned ADDR_W      = 26,
  parameter int unsigned MAX_PENDING = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  rasterizer_mem_arbiter_if.slave      bus,
  output logic [$clog2(MAX_PENDING):0] pending_count,
  output logic                         err_unexpected_rdv
);

  localparam int unsigned PW = $clog2(MAX_PENDING);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        fifo_q [MAX_PENDING];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [PW:0]       count_q;
  logic              err_q;

  logic              full, empty;
  logic [2:0]        elig;
  logic              pick_valid;
  logic [1:0]        pick;
  logic              sel_read, sel_write;
  logic [ADDR_W-1:0] sel_address;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;
  logic              m_read_c, m_write_c;
  logic [ADDR_W-1:0] m_address_c;
  logic [3:0]        m_be_c;
  logic [31:0]       m_wdata_c;
  logic [2:0]        s_wait_c;
  logic              push, pop;
  logic [1:0]        head;
  logic [2:0]        s_rdv_c;
  logic [95:0]       s_rdata_c;

  // FIFO status and per-requester eligibility (read+write counts as read)
  always_comb begin
    full  = (count_q == (PW+1)'(MAX_PENDING));
    empty = (count_q == '0);
    elig  = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      elig[k] = bus.s_read[k] ? !full : bus.s_write[k];
    end
  end

  // Winner selection used when leaving IDLE
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int unsigned k = 0; k < 3; k++) begin
      if (elig[k]) begin
        pick       = 2'(k);
        pick_valid = 1'b1;
      end
    end
`else
    for (int unsigned k = 0; k < 3; k++) begin
      int unsigned idx;
      idx = (32'(grant_q) + 1 + k) % 3;
      if (!pick_valid && elig[idx]) begin
        pick       = 2'(idx);
        pick_valid = 1'b1;
      end
    end
`endif
  end

  // Command mux from the currently granted requester
  always_comb begin
    sel_read    = 1'b0;
    sel_write   = 1'b0;
    sel_address = '0;
    sel_be      = '0;
    sel_wdata   = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (grant_q == 2'(k)) begin
        sel_read    = bus.s_read[k];
        sel_write   = bus.s_write[k];
        sel_address = bus.s_address[k*ADDR_W +: ADDR_W];
        sel_be      = bus.s_byteenable[k*4 +: 4];
        sel_wdata   = bus.s_writedata[k*32 +: 32];
      end
    end
  end

  // FSM next state, downstream command and requester waitrequest
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    m_read_c    = 1'b0;
    m_write_c   = 1'b0;
    m_address_c = '0;
    m_be_c      = '0;
    m_wdata_c   = '0;
    s_wait_c    = '1;
    push        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        m_read_c    = sel_read & !full;
        m_write_c   = sel_write & !sel_read;
        m_address_c = sel_address;
        m_be_c      = sel_be;
        m_wdata_c   = sel_wdata;
        for (int unsigned k = 0; k < 3; k++) begin
          if (grant_q == 2'(k)) s_wait_c[k] = bus.m_waitrequest;
        end
        // A dropped request abandons the grant without tracking anything
        if (!(m_read_c || m_write_c)) begin
          state_d = S_IDLE;
        end else if (!bus.m_waitrequest) begin
          state_d = S_IDLE;
          push    = m_read_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-return steering: head of the ID FIFO selects the lane
  always_comb begin
    pop       = bus.m_readdatavalid & !empty;
    head      = fifo_q[rptr_q];
    s_rdv_c   = '0;
    s_rdata_c = '0;
    if (pop) begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (head == 2'(k)) begin
          s_rdv_c[k]           = 1'b1;
          s_rdata_c[k*32 +: 32] = bus.m_readdata;
        end
      end
    end
  end

  assign bus.m_read          = m_read_c;
  assign bus.m_write         = m_write_c;
  assign bus.m_address       = m_address_c;
  assign bus.m_byteenable    = m_be_c;
  assign bus.m_writedata     = m_wdata_c;
  assign bus.s_waitrequest   = s_wait_c;
  assign bus.s_readdatavalid = s_rdv_c;
  assign bus.s_readdata      = s_rdata_c;
  assign pending_count       = count_q;
  assign err_unexpected_rdv  = err_q;

  // FSM state and grant history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= 2'd2;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Read-ID FIFO, occupancy and sticky unexpected-return flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_q  <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= grant_q;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (bus.m_readdatavalid && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// Directed bench for rasterizer_mem_arbiter with a read-return scoreboard.
module tb_rasterizer_mem_arbiter;

  localparam int unsigned AW = 26;
  localparam int unsigned MP = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [$clog2(MP):0] pending_count;
  logic err_unexpected_rdv;

  rasterizer_mem_arbiter_if #(.ADDR_W(AW)) bus ();

  rasterizer_mem_arbiter #(.ADDR_W(AW), .MAX_PENDING(MP)) dut (
    .clock              (clock),
    .reset              (reset),
    .bus                (bus),
    .pending_count      (pending_count),
    .err_unexpected_rdv (err_unexpected_rdv)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          lane;
    logic [31:0] data;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   lanes[$];   // requesters of accepted reads, in issue order
  exp_t exp_q[$];   // expected read returns
  exp_t mon_e;
  logic [95:0] mon_ev;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every read return must match the oldest expected entry
  always @(negedge clock) begin
    if (reset && (|bus.s_readdatavalid)) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 96'(bus.s_readdatavalid), 96'd0);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ev = '0;
        mon_ev[mon_e.lane*32 +: 32] = mon_e.data;
        chk("sb_rdv", 96'(bus.s_readdatavalid), 96'(3'(1 << mon_e.lane)));
        chk("sb_rdata", bus.s_readdata, mon_ev);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic reset_dut();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    lanes.delete();
    exp_q.delete();
  endtask

  // One Avalon transfer from requester i, held until accepted
  task automatic xfer(input int i, input bit rd, input logic [AW-1:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    bus.s_address[i*AW +: AW] = a;
    bus.s_writedata[i*32 +: 32] = d;
    bus.s_read[i]  = rd;
    bus.s_write[i] = !rd;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (!bus.s_waitrequest[i]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("xfer_accept", 96'(ok), 96'd1);
    if (ok) begin
      chk("xfer_addr", 96'(bus.m_address), 96'(a));
      chk("xfer_cmd", 96'({bus.m_read, bus.m_write}), 96'({rd, !rd}));
      chk("xfer_be", 96'(bus.m_byteenable), 96'(bus.s_byteenable[i*4 +: 4]));
      if (!rd) chk("xfer_wdata", 96'(bus.m_writedata), 96'(d));
    end
    @(posedge clock);
    #1;
    bus.s_read[i]  = 1'b0;
    bus.s_write[i] = 1'b0;
    if (ok && rd) lanes.push_back(i);
  endtask

  // One downstream read return; the expectation comes from the issue order
  task automatic rd_return(input logic [31:0] d);
    exp_t e;
    bit   expect_one;
    expect_one = (lanes.size() > 0);
    if (expect_one) begin
      e.lane = lanes.pop_front();
      e.data = d;
      exp_q.push_back(e);
    end
    bus.m_readdatavalid = 1'b1;
    bus.m_readdata      = d;
    @(negedge clock);
    if (!expect_one) chk("rdv_dropped", 96'(bus.s_readdatavalid), 96'd0);
    @(posedge clock);
    #1;
    bus.m_readdatavalid = 1'b0;
    bus.m_readdata      = '0;
    chk("sb_drained", 96'(exp_q.size()), 96'd0);
  endtask

  initial begin
    int n;
    int w;
    bit ok;
    int exp_lane;
    bus.s_address       = '0;
    bus.s_read          = '0;
    bus.s_write         = '0;
    bus.s_byteenable    = 12'h3F1;
    bus.s_writedata     = '0;
    bus.m_readdata      = '0;
    bus.m_readdatavalid = 1'b0;
    bus.m_waitrequest   = 1'b0;

    // Reset state
    #12;
    chk("rst_wait", 96'(bus.s_waitrequest), 96'h7);
    chk("rst_mcmd", 96'({bus.m_read, bus.m_write}), 96'd0);
    chk("rst_maddr", 96'({bus.m_address, bus.m_byteenable, bus.m_writedata}), 96'd0);
    chk("rst_rdv", 96'(bus.s_readdatavalid), 96'd0);
    chk("rst_rdata", bus.s_readdata, 96'd0);
    chk("rst_pending", 96'(pending_count), 96'd0);
    chk("rst_err", 96'(err_unexpected_rdv), 96'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Single read from requester 0: m_read one cycle after the request
    bus.s_address[0 +: AW] = 26'h0000100;
    bus.s_read[0] = 1'b1;
    @(negedge clock);
    chk("lat_cycle0", 96'(bus.m_read), 96'd0);
    @(negedge clock);
    chk("lat_cycle1", 96'(bus.m_read), 96'd1);
    chk("lat_addr", 96'(bus.m_address), 96'h100);
    chk("lat_wait", 96'(bus.s_waitrequest), 96'h6);
    @(posedge clock);
    #1 bus.s_read[0] = 1'b0;
    lanes.push_back(0);
    chk("single_pend1", 96'(pending_count), 96'd1);
    repeat (2) @(posedge clock);
    #1 rd_return(32'hDEADBEEF);
    chk("single_pend0", 96'(pending_count), 96'd0);

    // All three requesting continuously: grant order
    reset_dut();
    bus.s_address = {26'h0000300, 26'h0000200, 26'h0000100};
    bus.s_writedata = {32'hCAFE0002, 32'h0, 32'h0};
    bus.s_read  = 3'b011;
    bus.s_write = 3'b100;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clock);
      if ((bus.m_read || bus.m_write) && !bus.m_waitrequest) begin
        w = 3;
        for (int k = 0; k < 3; k++) if (!bus.s_waitrequest[k]) w = k;
`ifdef ARB_FIXED_PRIORITY_EN
        exp_lane = 2;
`else
        exp_lane = n % 3;
`endif
        chk("arb_grant", 96'(w), 96'(exp_lane));
        if (bus.m_read && w < 3) lanes.push_back(w);
        n++;
      end
    end
    chk("arb_count", 96'(n), 96'd6);
    @(posedge clock);
    #1;
    bus.s_read  = '0;
    bus.s_write = '0;
    n = 0;
    while (lanes.size() > 0) begin
      rd_return(32'hA0000000 + 32'(n));
      n++;
    end
    chk("arb_pend0", 96'(pending_count), 96'd0);

    // Reads from 1 then 0, in-order returns, plus a write from 2
    xfer(1, 1'b1, 26'h0000040, 32'h0);
    xfer(0, 1'b1, 26'h0000080, 32'h0);
    xfer(2, 1'b0, 26'h00000C0, 32'h12345678);
    chk("order_pend2", 96'(pending_count), 96'd2);
    rd_return(32'h11111111);
    rd_return(32'h22222222);
    chk("order_pend0", 96'(pending_count), 96'd0);

    // FIFO full: reads blocked, writes still served
    reset_dut();
    for (int k = 0; k < 8; k++) xfer(1, 1'b1, 26'(32'h1000 + k), 32'h0);
    chk("full_pend8", 96'(pending_count), 96'd8);
    bus.s_address[0 +: AW] = 26'h0002000;
    bus.s_address[2*AW +: AW] = 26'h0003000;
    bus.s_writedata[64 +: 32] = 32'h5A5A5A5A;
    bus.s_read[0]  = 1'b1;
    bus.s_write[2] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clock);
      chk("full_rd_blocked", 96'({bus.m_read, bus.s_waitrequest[0]}), 96'b01);
      if (!bus.s_waitrequest[2]) ok = 1'b1;
    end
    chk("full_wr_accept", 96'(ok), 96'd1);
    @(posedge clock);
    #1 bus.s_write[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("full_rd_held", 96'({bus.m_read, bus.s_waitrequest[0]}), 96'b01);
      @(posedge clock);
      #1;
    end
    rd_return(32'hBBBB0000);
    chk("full_pend7", 96'(pending_count), 96'd7);
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clock);
      if (!bus.s_waitrequest[0] && bus.m_read) ok = 1'b1;
    end
    chk("full_rd_issue", 96'(ok), 96'd1);
    @(posedge clock);
    #1 bus.s_read[0] = 1'b0;
    if (ok) lanes.push_back(0);
    chk("full_pend8b", 96'(pending_count), 96'd8);
    for (int k = 0; k < 8; k++) rd_return(32'hC0000000 + 32'(k));
    chk("full_pend0", 96'(pending_count), 96'd0);

    // Unexpected return with the FIFO empty
    rd_return(32'hFFFF0000);
    chk("unexp_err", 96'(err_unexpected_rdv), 96'd1);
    repeat (3) @(posedge clock);
    #1 chk("unexp_sticky", 96'(err_unexpected_rdv), 96'd1);
    chk("unexp_pend", 96'(pending_count), 96'd0);

    // Reset while a read is stalled in GRANT
    bus.m_waitrequest = 1'b1;
    bus.s_address[0 +: AW] = 26'h0000500;
    bus.s_read[0] = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("rstg_mread", 96'(bus.m_read), 96'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstg_mread0", 96'(bus.m_read), 96'd0);
    chk("rstg_wait", 96'(bus.s_waitrequest), 96'h7);
    chk("rstg_pend", 96'(pending_count), 96'd0);
    chk("rstg_err", 96'(err_unexpected_rdv), 96'd0);
    bus.s_read = '0;
    bus.m_waitrequest = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rasterizer_mem_arbiter.md
Name: rasterizer_mem_arbiter

Overview:
- Shares one Avalon-MM SDRAM master port between the three rasterizer pipeline masters: 0 = vertex fetch (reads), 1 = depth fetch (reads), 2 = z-test/colour write (writes, possibly reads).
- Grants one transfer at a time and forwards the winner's command downstream.
- Tracks outstanding reads in an ID FIFO so each returned read word is steered to the requester that issued it.
- Sits between the rasterizer unit's three master ports and the SDRAM controller.

Parameters:
ADDR_W, 26, address width of requester and downstream ports
MAX_PENDING, 8, depth of read-ID FIFO = max outstanding reads (power of 2, >=2)

Ports:
clock  in  1  single system clock
reset  in  1  asynchronous, active-low reset
s_address  in  3*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
s_read  in  3  read request per requester
s_write  in  3  write request per requester
s_byteenable  in  12  4 bits per requester
s_writedata  in  96  32 bits per requester
s_waitrequest  out  3  per-requester waitrequest
s_readdata  out  96  32 bits per requester
s_readdatavalid  out  3  per-requester read-return strobe
m_address  out  ADDR_W  downstream address
m_read  out  1  downstream read
m_write  out  1  downstream write
m_byteenable  out  4  downstream byteenable
m_writedata  out  32  downstream write data
m_readdata  in  32  downstream read data
m_readdatavalid  in  1  downstream read-return strobe
m_waitrequest  in  1  downstream waitrequest
pending_count  out  $clog2(MAX_PENDING)+1  reads currently outstanding
err_unexpected_rdv  out  1  sticky: readdatavalid seen while FIFO empty

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, grant=2 (so requester 0 wins first RR pass), FIFO empty, pending_count=0, err_unexpected_rdv=0.
  - m_read=m_write=0; m_address/m_byteenable/m_writedata=0.
  - s_waitrequest=3'b111, s_readdatavalid=0, s_readdata=0.
- Requester i is eligible when s_write[i] | s_read[i]. A read is eligible only if the FIFO is not full; writes are eligible regardless.
- s_read[i] & s_write[i] together is illegal; the arbiter issues the read only.
- FSM:
  - IDLE: if any eligible requester, choose one round-robin starting at (grant+1) mod 3, register grant, go GRANT. Else stay IDLE.
  - GRANT: drive m_* from s_*[grant] combinationally (m_read/m_write gated by eligibility). s_waitrequest[grant] = m_waitrequest; all other bits = 1.
  - Accept = GRANT & (m_read|m_write) & !m_waitrequest. On accept, go IDLE.
  - If the granted requester drops its request before acceptance (illegal in Avalon), go IDLE without pushing.
- Latency: request to first downstream assertion = 1 cycle. Maximum throughput is 1 transfer per 2 cycles. The IDLE bubble is intentional.
- Read tracking:
  - Each accepted read pushes grant (2 bits) into the FIFO.
  - On m_readdatavalid: pop head h; s_readdatavalid[h]=1 and s_readdata lane h = m_readdata in the same cycle (combinational). Other lanes hold 0.
  - Push and pop in the same cycle are allowed; pending_count is unchanged.
  - Pointers wrap modulo MAX_PENDING.
- FIFO full (pending_count==MAX_PENDING): no read grant occurs; pending writes are still granted.
- m_readdatavalid with empty FIFO: data is dropped, no s_readdatavalid, err_unexpected_rdv set to 1 until reset. This covers returns after a mid-transaction reset.
- Reset mid-GRANT: downstream command is deasserted immediately; the in-flight transfer is abandoned.

Optional Feature:
ARB_FIXED_PRIORITY_EN
- Defined: IDLE selects a fixed priority 2 > 1 > 0, so the z-test drains the pipeline first and grant history is ignored.
- Undefined: round-robin as above.
- Latency and read tracking are identical in both modes.

Test Plan:
- Single read, requester 0, addr 0x0000100, m_waitrequest=0, data 0xDEADBEEF after 3 cycles -> m_read high at cycle 1; s_readdatavalid=3'b001 with lane 0 = 0xDEADBEEF; pending_count 1 then 0.
- All three request continuously, 0/1 read, 2 write -> grant order 0,1,2,0,1,2 (round-robin build); 2,2,2 while 2 keeps requesting (fixed-priority build).
- Reads from 1 then 0 with in-order returns 0x11111111, 0x22222222 -> lane 1 gets 0x11111111 first, lane 0 gets 0x22222222 second.
- 8 reads outstanding with no returns, then requester 0 reads and requester 2 writes -> read blocked with s_waitrequest[0]=1, write to 2 accepted; the read issues in the cycle after one return pops.
- m_readdatavalid pulse with FIFO empty -> no s_readdatavalid; err_unexpected_rdv=1 and stays 1 until reset.
- Reset asserted during GRANT with m_waitrequest=1 -> m_read=0 asynchronously, s_waitrequest=3'b111, pending_count=0.
